simpletest_sched: RTL and testbench
===================================

SIMPLETEST_SCHED -- requirements
Module: simpletest_sched

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter LATENCY, default 2, legal 1..15, meaning datapath cycles from stable operands to valid dp_out.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester N's operation accepted this cycle.
REQ-007 req0_op1, req0_op2 / req1_op1, req1_op2  input  DW  operands of requester N.
REQ-008 req0_sel / req1_sel  input  2  select field of requester N.
REQ-009 req0_key / req1_key  input  1  key bit of requester N.
REQ-010 dp_op1, dp_op2  output  DW  operands driven to the shared datapath.
REQ-011 dp_sel  output  2; dp_key  output  1  control driven to the shared datapath.
REQ-012 dp_out  input  DW  shared datapath result.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_data  output  DW  captured result; rsp_id  output  1  index of the requester that owns the result.
REQ-015 done_cnt  output  16  count of completed response handshakes.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-017 In IDLE, reqN_ready SHALL be 1 combinationally only for the granted requester with reqN_valid=1; in BUSY and RESP, both readies SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not granted last; the last-grant pointer SHALL update only on an accepted handshake.
REQ-019 On a request handshake (valid and ready), the block SHALL register that requester's op1, op2, sel and key into dp_* and its index into rsp_id, load the cycle counter with LATENCY, and enter BUSY.
REQ-020 dp_* SHALL hold their values unchanged until the next request handshake.
REQ-021 In BUSY, the counter SHALL decrement each cycle; on the edge ending the LATENCY-th BUSY cycle, rsp_data SHALL capture dp_out and the FSM SHALL enter RESP.
REQ-022 rsp_valid SHALL be 1 exactly in RESP, so rsp_valid rises LATENCY+1 cycles after the request handshake edge.
REQ-023 In RESP, rsp_data and rsp_id SHALL stay stable until rsp_ready=1; on that edge the FSM SHALL enter IDLE and done_cnt SHALL increment, wrapping 0xFFFF to 0x0000.
REQ-024 A new grant SHALL NOT occur in the cycle the response handshake completes; the earliest next request handshake is the following cycle, so the minimum issue interval is LATENCY+2 cycles.
REQ-025 A requester that drops valid without a handshake SHALL have no effect on state or on the pointer.

Reset
REQ-026 While rst=0, the block SHALL be in IDLE and all outputs SHALL be 0, including dp_*, rsp_*, done_cnt and the counter; the pointer SHALL be 1 so that req0 wins the first contention.
REQ-027 A reset asserted in BUSY or RESP SHALL discard the in-flight operation; no rsp_valid SHALL follow reset release.

Configuration
REQ-028 Macro SIMPLETEST_SCHED_FIXED_PRIO_EN: when defined, req0 SHALL always win when both requesters are valid and the pointer is unused; when undefined, REQ-018 round-robin applies.

Verification
REQ-029 With LATENCY=2, release reset, then req0 presents op1=0x05, op2=0x03, sel=1, key=0, and the datapath model returns 0x2A -> rsp_valid=1 three cycles after the handshake edge, with rsp_data=0x2A, rsp_id=0 and done_cnt=1 after rsp_ready.
REQ-030 Both requesters held valid, rsp_ready=1 -> grant order 0,1,0,1 without the macro; with SIMPLETEST_SCHED_FIXED_PRIO_EN, grant order 0,0,0,0; each issue interval is 4 cycles.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, both readies 0 and dp_* unchanged throughout.
REQ-032 rst=0 during the second BUSY cycle -> all outputs 0 next cycle; after release, with no new requests, no rsp_valid and done_cnt=0.
REQ-033 done_cnt at 0xFFFF followed by one completed response -> done_cnt=0x0000.
REQ-034 rsp_ready=1 when rsp_valid rises -> one-cycle rsp_valid pulse, IDLE next cycle, and the next reqN_ready no earlier than that IDLE cycle.

Source files
------------

// File: rtl/simpletest_sched.sv
// simpletest_sched: two-requester scheduler for a shared multi-cycle datapath.
// One operation is in flight at a time: IDLE -> BUSY (LATENCY cycles) -> RESP.
// The result is captured from the datapath and held until the consumer takes it.
// Optional macro SIMPLETEST_SCHED_FIXED_PRIO_EN: req0 always wins when both
// requesters are valid. Without it, arbitration is round-robin.
module simpletest_sched #(
    parameter int DW      = 8,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_op1,
    input  logic [DW-1:0] req0_op2,
    input  logic [1:0]    req0_sel,
    input  logic          req0_key,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_op1,
    input  logic [DW-1:0] req1_op2,
    input  logic [1:0]    req1_sel,
    input  logic          req1_key,
    output logic [DW-1:0] dp_op1,
    output logic [DW-1:0] dp_op2,
    output logic [1:0]    dp_sel,
    output logic          dp_key,
    input  logic [DW-1:0] dp_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_id,
    output logic [15:0]   done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;          // index of the last granted requester
    logic [3:0]    cnt_q, cnt_d;          // remaining BUSY cycles
    logic [DW-1:0] dp_op1_q, dp_op1_d;
    logic [DW-1:0] dp_op2_q, dp_op2_d;
    logic [1:0]    dp_sel_q, dp_sel_d;
    logic          dp_key_q, dp_key_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_id_q, rsp_id_d;
    logic [15:0]   done_cnt_q, done_cnt_d;

    logic          grant_any;             // at least one requester is pending
    logic          grant_id;              // requester that would win this cycle
    logic          accept;                // a request handshake happens this cycle

    // Arbitration: pick the winner among the pending requesters.
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef SIMPLETEST_SCHED_FIXED_PRIO_EN
        grant_id  = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant_id = ~ptr_q;
        end else begin
            grant_id = ~req0_valid;
        end
`endif
    end

    // Readies are only offered in IDLE, and never while reset is held.
    always_comb begin
        accept     = rst && (state_q == IDLE) && grant_any;
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
    end

    // Next-state and datapath/result register updates.
    always_comb begin
        // NOTE: every _d starts from its hold value so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dp_op1_d   = dp_op1_q;
        dp_op2_d   = dp_op2_q;
        dp_sel_d   = dp_sel_q;
        dp_key_d   = dp_key_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        done_cnt_d = done_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    dp_op1_d = grant_id ? req1_op1 : req0_op1;
                    dp_op2_d = grant_id ? req1_op2 : req0_op2;
                    dp_sel_d = grant_id ? req1_sel : req0_sel;
                    dp_key_d = grant_id ? req1_key : req0_key;
                    rsp_id_d = grant_id;
                    ptr_d    = grant_id;
                    cnt_d    = 4'(LATENCY);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_data_d = dp_out;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: operand and result registers are reset as well because they drive outputs that must read 0 in reset.
            state_q    <= IDLE;
            ptr_q      <= 1'b1;
            cnt_q      <= '0;
            dp_op1_q   <= '0;
            dp_op2_q   <= '0;
            dp_sel_q   <= '0;
            dp_key_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dp_op1_q   <= dp_op1_d;
            dp_op2_q   <= dp_op2_d;
            dp_sel_q   <= dp_sel_d;
            dp_key_q   <= dp_key_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign dp_op1    = dp_op1_q;
    assign dp_op2    = dp_op2_q;
    assign dp_sel    = dp_sel_q;
    assign dp_key    = dp_key_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_simpletest_sched.sv
// Self-checking bench for simpletest_sched: a cycle-level reference model
// predicts readies, rsp_valid timing and dp_* contents, and pushes expected
// responses into a scoreboard that a separate monitor drains on rsp handshakes.
module tb_simpletest_sched;

    localparam int DW      = 8;
    localparam int LATENCY = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [1:0]    req0_sel = '0, req1_sel = '0;
    logic          req0_key = 1'b0, req1_key = 1'b0;
    logic [DW-1:0] dp_op1, dp_op2, dp_out, rsp_data;
    logic [1:0]    dp_sel;
    logic          dp_key, rsp_valid, rsp_id;
    logic          rsp_ready = 1'b0;
    logic [15:0]   done_cnt;

    simpletest_sched #(.DW(DW), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel), .req1_key(req1_key),
        .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_sel(dp_sel), .dp_key(dp_key), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
    endtask

    // Shared datapath stand-in: a small ALU, optionally overridden by a fixed value.
    int dp_override = -1;
    function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [1:0] s, input logic k);
        logic [DW-1:0] r;
        case (s)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a ^ b;
            default: r = a & b;
        endcase
        return k ? ~r : r;
    endfunction
    assign dp_out = (dp_override >= 0) ? DW'(dp_override) : alu(dp_op1, dp_op2, dp_sel, dp_key);

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: one operation at a time, response visible LATENCY+1
    // cycles after the accepting cycle, idle again the cycle after rsp handshake.
    bit            m_busy = 1'b0;
    int            m_rsp_cycle = 0;
    bit            m_last = 1'b1;
    logic [DW-1:0] m_op1 = '0, m_op2 = '0;
    logic [1:0]    m_sel = '0;
    logic          m_key = 1'b0;
    bit            m_exp_rv, m_any, m_id;
    exp_t          m_e;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; m_last = 1'b1;
            m_op1 = '0; m_op2 = '0; m_sel = '0; m_key = 1'b0;
            sb_q.delete();
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_rsp_valid",  rsp_valid, 0);
            check("rst_rsp_data",   rsp_data, 0);
            check("rst_rsp_id",     rsp_id, 0);
            check("rst_dp_op1",     dp_op1, 0);
            check("rst_dp_op2",     dp_op2, 0);
            check("rst_dp_sel",     dp_sel, 0);
            check("rst_dp_key",     dp_key, 0);
            check("rst_done_cnt",   done_cnt, 0);
        end else begin
            m_exp_rv = m_busy && (cyc >= m_rsp_cycle);
            m_any    = !m_busy && (req0_valid || req1_valid);
            if (req0_valid && req1_valid) begin
`ifdef SIMPLETEST_SCHED_FIXED_PRIO_EN
                m_id = 1'b0;
`else
                m_id = !m_last;
`endif
            end else begin
                m_id = !req0_valid;
            end
            check("req0_ready", req0_ready, m_any && !m_id);
            check("req1_ready", req1_ready, m_any && m_id);
            check("rsp_valid",  rsp_valid, m_exp_rv);
            check("dp_op1", dp_op1, m_op1);
            check("dp_op2", dp_op2, m_op2);
            check("dp_sel", dp_sel, m_sel);
            check("dp_key", dp_key, m_key);
            if (m_any) begin
                m_op1 = m_id ? req1_op1 : req0_op1;
                m_op2 = m_id ? req1_op2 : req0_op2;
                m_sel = m_id ? req1_sel : req0_sel;
                m_key = m_id ? req1_key : req0_key;
                m_e.id   = m_id;
                m_e.data = (dp_override >= 0) ? DW'(dp_override) : alu(m_op1, m_op2, m_sel, m_key);
                sb_q.push_back(m_e);
                m_busy      = 1'b1;
                m_rsp_cycle = cyc + LATENCY + 1;
                m_last      = m_id;
            end else if (m_exp_rv && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Monitor: compares presented responses to the scoreboard head.
    logic [15:0] exp_done = '0;
    bit          done_pending = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_done     = '0;
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                check("done_cnt", done_cnt, exp_done);
                done_pending = 1'b0;
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    check("rsp_data", rsp_data, sb_q[0].data);
                    check("rsp_id",   rsp_id, sb_q[0].id);
                    if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        exp_done     = exp_done + 16'd1;
                        done_pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        req0_op1 = DW'($urandom); req0_op2 = DW'($urandom);
        req0_sel = 2'($urandom);  req0_key = 1'($urandom);
        req1_op1 = DW'($urandom); req1_op2 = DW'($urandom);
        req1_sel = 2'($urandom);  req1_key = 1'($urandom);
    endtask

    // Waits (bounded) for the given requester's ready; returns the accepting cycle.
    task automatic wait_grant(input bit which, output int hs);
        hs = -1;
        for (int i = 0; i < 40 && hs < 0; i++) begin
            @(negedge clk);
            if (which ? req1_ready : req0_ready) hs = cyc;
            step();
        end
        if (hs < 0) fail_now(which ? "req1_grant_wait" : "req0_grant_wait");
    endtask

    int hs_cyc, rv_cyc;
    int g_ids[$];
    int g_cyc[$];

    initial begin
        // Reset with requests pending: readies must stay low.
        req0_valid = 1'b1; req1_valid = 1'b1; rand_ops();
        repeat (3) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        step();

        // Single operation with a fixed datapath result, then a 5-cycle stall in RESP.
        dp_override = 'h2A;
        rsp_ready = 1'b0;
        req0_op1 = 8'h05; req0_op2 = 8'h03; req0_sel = 2'd1; req0_key = 1'b0;
        req0_valid = 1'b1;
        wait_grant(1'b0, hs_cyc);
        req0_valid = 1'b0;
        rv_cyc = -1;
        for (int i = 0; i < 20 && rv_cyc < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) rv_cyc = cyc;
            else step();
        end
        if (rv_cyc < 0) fail_now("rsp_valid_wait");
        else check("rsp_latency", rv_cyc - hs_cyc, LATENCY + 1);
        step();
        req0_valid = 1'b1; req1_valid = 1'b1; rand_ops();
        repeat (4) begin step(); rand_ops(); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        @(negedge clk);
        check("done_cnt_first", done_cnt, 1);
        step();
        dp_override = -1;

        // Reset during the second BUSY cycle discards the operation.
        rand_ops();
        req1_valid = 1'b1;
        wait_grant(1'b1, hs_cyc);
        req1_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (8) step();
        @(negedge clk);
        check("done_cnt_after_reset", done_cnt, 0);
        step();

        // Both requesters held valid: grant order and issue interval.
        req0_valid = 1'b1; req1_valid = 1'b1; rand_ops();
        for (int i = 0; i < 60 && g_ids.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin g_ids.push_back(0); g_cyc.push_back(cyc); end
            else if (req1_ready) begin g_ids.push_back(1); g_cyc.push_back(cyc); end
            step();
            rand_ops();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (g_ids.size() < 4) begin
            fail_now("grant_sequence_wait");
        end else begin
            for (int k = 0; k < 4; k++) begin
`ifdef SIMPLETEST_SCHED_FIXED_PRIO_EN
                check("grant_order", g_ids[k], 0);
`else
                check("grant_order", g_ids[k], k % 2);
`endif
                if (k > 0) check("issue_interval", g_cyc[k] - g_cyc[k-1], LATENCY + 2);
            end
        end
        repeat (10) step();

        // done_cnt wrap from 0xFFFF.
        force dut.done_cnt_q = 16'hFFFF;
        step();
        release dut.done_cnt_q;
        exp_done = 16'hFFFF;
        @(negedge clk);
        check("done_cnt_preset", done_cnt, 16'hFFFF);
        step();
        rand_ops();
        req0_valid = 1'b1;
        wait_grant(1'b0, hs_cyc);
        req0_valid = 1'b0;
        repeat (LATENCY + 4) step();
        @(negedge clk);
        check("done_cnt_wrap", done_cnt, 16'h0000);
        step();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 99) < 50);
            req1_valid = ($urandom_range(0, 99) < 50);
            rsp_ready  = ($urandom_range(0, 99) < 60);
            rand_ops();
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (LATENCY + 10) step();
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
